// File: rtl/batch_dispatch_if.sv
// Purpose: bundles the insertion side, the executor dispatch channel, completions and batch status of batch_dispatch.
// Latency: none, wires only.
// Backpressure: the dispatch channel is valid/ready; insertion is gated by accept_ready (a pulse while low is dropped).
//
// Ports (slave = batch_dispatch view):
//   in : transaction_accepted, inserted_programID[63:0], flush, dispatch_ready, exec_complete
//   out: accept_ready, dispatch_valid, dispatch_programID[63:0], dispatch_index, batch_clear,
//        batch_id[7:0], batch_count, overflow
interface batch_dispatch_if #(
    parameter int BATCH_INDEX_BITS = 6
);
    logic                        transaction_accepted;
    logic [63:0]                 inserted_programID;
    logic                        flush;
    logic                        accept_ready;
    logic                        dispatch_valid;
    logic [63:0]                 dispatch_programID;
    logic [BATCH_INDEX_BITS-1:0] dispatch_index;
    logic                        dispatch_ready;
    logic                        exec_complete;
    logic                        batch_clear;
    logic [7:0]                  batch_id;
    logic [BATCH_INDEX_BITS-1:0] batch_count;
    logic                        overflow;

    modport master (
        output transaction_accepted, inserted_programID, flush, dispatch_ready, exec_complete,
        input  accept_ready, dispatch_valid, dispatch_programID, dispatch_index,
               batch_clear, batch_id, batch_count, overflow
    );

    modport slave (
        input  transaction_accepted, inserted_programID, flush, dispatch_ready, exec_complete,
        output accept_ready, dispatch_valid, dispatch_programID, dispatch_index,
               batch_clear, batch_id, batch_count, overflow
    );
endinterface

// File: rtl/batch_dispatch.sv
// Purpose: collects accepted program IDs into a batch, closes it (full/timeout/flush), dispatches the IDs
//          to the executor, waits for all completions and pulses batch_clear to retire the batch.
// Latency: dispatch_valid rises 1 cycle after the close condition; a batch of N retires N+3 cycles from close.
// Backpressure: dispatch entry holds while valid && !ready; accepts while accept_ready=0 are dropped (overflow).
//
// Ports: clk, rst (synchronous active-high); bus (batch_dispatch_if.slave) carries all handshake/status signals.
// Optional: define DISPATCH_STATS_EN to add stat_batches (batch_clear count) and stat_txs (dispatch
//           handshake count), both 32-bit and cleared only by rst.
module batch_dispatch #(
    parameter int MAX_BATCH_SIZE   = 48,
    parameter int BATCH_INDEX_BITS = 6,
    parameter int TIMEOUT_CYCLES   = 256,
    parameter int TIMEOUT_BITS     = 9
) (
    input  logic            clk,
    input  logic            rst,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]     stat_batches,
    output logic [31:0]     stat_txs,
`endif
    batch_dispatch_if.slave bus
);
    localparam logic [1:0] ST_COLLECT   = 2'd0;
    localparam logic [1:0] ST_DRAIN     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_CLEAR     = 2'd3;

    localparam logic [BATCH_INDEX_BITS-1:0] IDX_ONE  = 1;
    localparam logic [BATCH_INDEX_BITS-1:0] IDX_MAX  = BATCH_INDEX_BITS'(MAX_BATCH_SIZE);
    localparam logic [TIMEOUT_BITS-1:0]     TMR_ONE  = 1;
    localparam logic [TIMEOUT_BITS-1:0]     TMR_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    logic [1:0]                  state_q, state_d;
    logic [BATCH_INDEX_BITS-1:0] count_q, count_d;
    logic [BATCH_INDEX_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [BATCH_INDEX_BITS-1:0] done_cnt_q, done_cnt_d;
    logic [TIMEOUT_BITS-1:0]     timer_q, timer_d;
    logic [7:0]                  batch_id_q, batch_id_d;
    logic                        overflow_q, overflow_d;
    logic [63:0]                 buf_q [MAX_BATCH_SIZE];
    logic [63:0]                 buf_d [MAX_BATCH_SIZE];

    logic accept_ready;
    logic dispatch_valid;
    logic wr_en;
    logic dispatch_hs;
    logic done_inc;
    logic close_now;

    assign accept_ready   = (state_q == ST_COLLECT) && (count_q < IDX_MAX);
    assign dispatch_valid = (state_q == ST_DRAIN);
    assign wr_en          = bus.transaction_accepted && accept_ready;
    assign dispatch_hs    = dispatch_valid && bus.dispatch_ready;
    // Completions saturate at the batch size so stray pulses cannot push done_cnt past count.
    assign done_inc       = bus.exec_complete && (done_cnt_q < count_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        done_cnt_d = done_cnt_q;
        timer_d    = timer_q;
        batch_id_d = batch_id_q;
        buf_d      = buf_q;
        close_now  = 1'b0;
        overflow_d = overflow_q || (bus.transaction_accepted && !accept_ready);

        case (state_q)
            ST_COLLECT: begin
                if (wr_en) begin
                    buf_d[count_q] = bus.inserted_programID;
                    count_d        = count_q + IDX_ONE;
                end
                // Timer runs only while the batch holds entries, so it starts the cycle after the first write.
                if (count_q != '0) begin
                    timer_d = timer_q + TMR_ONE;
                end
                // A write in the closing cycle is already in count_d, so it joins this batch.
                close_now = (wr_en && (count_d == IDX_MAX))
                         || (bus.flush && ((count_q != '0) || wr_en))
                         || ((count_q != '0) && (timer_q == TMR_LAST));
                if (close_now) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (done_inc) begin
                    done_cnt_d = done_cnt_q + IDX_ONE;
                end
                if (dispatch_hs) begin
                    rd_ptr_d = rd_ptr_q + IDX_ONE;
                    if (rd_ptr_q == (count_q - IDX_ONE)) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (done_inc) begin
                    done_cnt_d = done_cnt_q + IDX_ONE;
                end
                if (done_cnt_q == count_q) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d    = ST_COLLECT;
                batch_id_d = batch_id_q + 8'd1;
                count_d    = '0;
                rd_ptr_d   = '0;
                done_cnt_d = '0;
                timer_d    = '0;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            done_cnt_q <= '0;
            timer_q    <= '0;
            batch_id_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            done_cnt_q <= done_cnt_d;
            timer_q    <= timer_d;
            batch_id_q <= batch_id_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer contents are don't-care after reset; only count_q decides which slots are live.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.accept_ready       = accept_ready;
    assign bus.dispatch_valid     = dispatch_valid;
    // rd_ptr_q may point one past the last slot outside DRAIN, so the read is masked there.
    assign bus.dispatch_programID = dispatch_valid ? buf_q[rd_ptr_q] : 64'd0;
    assign bus.dispatch_index     = dispatch_valid ? rd_ptr_q : '0;
    assign bus.batch_clear        = (state_q == ST_CLEAR);
    assign bus.batch_id           = batch_id_q;
    assign bus.batch_count        = count_q;
    assign bus.overflow           = overflow_q;

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_batches_q, stat_batches_d;
    logic [31:0] stat_txs_q, stat_txs_d;

    always_comb begin
        stat_batches_d = stat_batches_q + ((state_q == ST_CLEAR) ? 32'd1 : 32'd0);
        stat_txs_d     = stat_txs_q + (dispatch_hs ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_batches_q <= '0;
            stat_txs_q     <= '0;
        end else begin
            stat_batches_q <= stat_batches_d;
            stat_txs_q     <= stat_txs_d;
        end
    end

    assign stat_batches = stat_batches_q;
    assign stat_txs     = stat_txs_q;
`endif
endmodule

// File: doc/batch_dispatch.md
Name: batch_dispatch

Overview:
- Downstream end of the batch-insertion interface.
- Collects accepted transactions, identified by the accepted pulse plus the 64-bit program ID, into a batch buffer.
- Closes the batch when it is full, on timeout, or on flush, then hands the IDs to the executor over a valid/ready channel.
- Waits for every execution to complete, then pulses batch_clear so the conflict filter and batch stage can reset for the next batch.

Parameters:
- MAX_BATCH_SIZE, 48, max entries per batch
- BATCH_INDEX_BITS, 6, width of index/count (must hold MAX_BATCH_SIZE)
- TIMEOUT_CYCLES, 256, cycles after first entry before a partial batch is closed
- TIMEOUT_BITS, 9, timer width (must hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- transaction_accepted  in  1  one-cycle pulse, ID valid
- inserted_programID  in  64  program ID to enqueue
- flush  in  1  force-close current batch
- accept_ready  out  1  high only in COLLECT and count<MAX_BATCH_SIZE
- dispatch_valid  out  1  ID presented to executor
- dispatch_programID  out  64  entry at read pointer
- dispatch_index  out  BATCH_INDEX_BITS  slot of presented entry
- dispatch_ready  in  1  executor takes entry
- exec_complete  in  1  one pulse per finished transaction
- batch_clear  out  1  one-cycle pulse, batch retired
- batch_id  out  8  current batch number
- batch_count  out  BATCH_INDEX_BITS  entries in current batch
- overflow  out  1  sticky, an accept was dropped

Behaviour:
- Reset (rst=1 at clk edge, any state): state=COLLECT, count=0, rd_ptr=0, done_cnt=0, timer=0, batch_id=0. All outputs 0 except accept_ready=1. Buffer contents are don't-care.
- COLLECT
  - transaction_accepted with count<MAX: write buf[count], count+1.
  - Timer starts the cycle after the first write and increments each cycle while count>0.
  - Close (move to DRAIN next cycle) when any of:
    - count reaches MAX after a write;
    - flush=1 and (count>0 or a write is in the same cycle);
    - timer==TIMEOUT_CYCLES-1 with count>0.
  - A same-cycle accept is included in the closing batch.
  - flush with an empty batch and no write is ignored.
- DRAIN
  - dispatch_valid=1 from the first DRAIN cycle, which is 1 cycle after the close condition.
  - dispatch_programID=buf[rd_ptr], dispatch_index=rd_ptr; both hold stable while valid && !ready.
  - On valid&&ready: rd_ptr+1. The handshake on entry count-1 moves to WAIT_DONE, and dispatch_valid drops the next cycle.
- WAIT_DONE: no dispatch. When done_cnt==count, move to CLEAR.
- exec_complete
  - Counted in both DRAIN and WAIT_DONE, since completions may overtake the drain.
  - done_cnt saturates at count; excess pulses are ignored.
  - Ignored in COLLECT and CLEAR.
- CLEAR
  - One cycle: batch_clear=1.
  - Next edge: batch_id+1 (wraps 255→0); count, rd_ptr, done_cnt and timer go to 0; return to COLLECT.
- Drops: transaction_accepted while accept_ready=0 drops the ID and sets overflow. overflow clears only on rst.
- Throughput: 1 ID per cycle with dispatch_ready held high. A batch of N with completions arriving during drain retires in N+3 cycles from the close edge.
- batch_count is a registered reflection of count.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- When defined, adds two outputs, both cleared only by rst:
  - stat_batches out 32: increments on each batch_clear.
  - stat_txs out 32: increments on each dispatch handshake.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Full batch: 48 accept pulses with IDs 0x100..0x12F, dispatch_ready=1, completions at 1/cycle → 48 dispatches in order, index 0..47, batch_clear once, batch_id=1.
- Timeout: 3 accepts (0xA,0xB,0xC) then idle → DRAIN entered exactly 256 cycles after first write, 3 IDs dispatched, clear after 3 completions.
- Flush + accept same cycle: 2 accepts, then accept 0x77 with flush → batch_count=3, 0x77 dispatched at index 2.
- Backpressure: dispatch_ready toggled 0/1 every cycle → each ID held stable until handshake, no duplicates or skips.
- Drop during drain: accept 0xDEAD while in DRAIN → not stored, overflow=1, batch_count unchanged.
- Reset mid-DRAIN after 5 of 10 dispatched → next cycle dispatch_valid=0, accept_ready=1, batch_id=0, batch_clear never pulsed.
